// File: rtl/dma_channel_arbiter.sv
// Registered DREQ/DACK arbiter: one grant at a time, fixed or rotating priority,
// held until the timing FSM reports end of service.
module dma_channel_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int IDX_W      = $clog2(NUM_CH),
  parameter bit DREQ_ACTLO = 1'b0,
  parameter bit DACK_ACTLO = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              masterClear,
  input  logic              priorityType,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              assertDACK,
  input  logic              transferDone,
  output logic [NUM_CH-1:0] DACK,
  output logic              grantValid,
  output logic [IDX_W-1:0]  grantChannel
);

  // state   | meaning
  // S_IDLE  | no grant; arbitrate when assertDACK and a channel is eligible
  // S_GRANT | one channel acknowledged; held until transferDone
  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]  r_ch, w_ch_nxt;
  logic [NUM_CH-1:0] r_dack, w_dack_nxt;
  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_win_onehot;
  logic [IDX_W-1:0]  w_win;
  logic [IDX_W-1:0]  w_ptr_adv;
  logic              w_found;

  assign w_req = (DREQ ^ {NUM_CH{DREQ_ACTLO}}) & ~maskReg;

  // Search starts at ptr in rotating mode, at 0 in fixed mode; first eligible wins.
  always_comb begin : winner_search
    int               idx;
    logic [IDX_W-1:0] cand;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    cand    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx  = priorityType ? ((int'(r_ptr) + k) % NUM_CH) : k;
      cand = IDX_W'(idx);
      if (!w_found && w_req[cand]) begin
        w_found = 1'b1;
        w_win   = cand;
      end
    end
  end

  assign w_win_onehot = NUM_CH'(1) << w_win;
  assign w_ptr_adv    = (w_win == IDX_W'(NUM_CH - 1)) ? '0 : (w_win + IDX_W'(1));

  always_comb begin : next_state
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_ch_nxt    = r_ch;
    w_dack_nxt  = r_dack;
    if (masterClear) begin
      w_state_nxt = S_IDLE;
      w_ptr_nxt   = '0;
      w_ch_nxt    = '0;
      w_dack_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (assertDACK && w_found) begin
            w_state_nxt = S_GRANT;
            w_ch_nxt    = w_win;
            w_dack_nxt  = w_win_onehot;
            if (priorityType) w_ptr_nxt = w_ptr_adv;
          end
        end
        S_GRANT: begin
          // Release forces a full idle cycle before the next arbitration.
          if (transferDone) begin
            w_state_nxt = S_IDLE;
            w_ch_nxt    = '0;
            w_dack_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_ch_nxt    = '0;
          w_dack_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_ch    <= '0;
      r_dack  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ch    <= w_ch_nxt;
      r_dack  <= w_dack_nxt;
    end
  end

  assign DACK         = r_dack ^ {NUM_CH{DACK_ACTLO}};
  assign grantValid   = (r_state == S_GRANT);
  assign grantChannel = r_ch;

endmodule
